// File: rtl/demux8_rr_sched_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : demux8_rr_sched_pkg
// Desc     : Shared sizes, burst length and FSM state type for the scheduler.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package demux8_rr_sched_pkg;

   localparam int N_CH      = 8;
   localparam int SEL_W     = $clog2(N_CH);
   localparam int CNT_W     = 4;
   localparam int BURST_LEN = 4;   // 1..15, only used with DEMUX_BURST_EN

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_XFER   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/demux8_rr_sched_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : demux8_rr_sched_if
// Desc     : Source stream, channel config/ready and demux control bundle.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface demux8_rr_sched_if;
   import demux8_rr_sched_pkg::*;

   logic              in_valid;
   logic              in_data;
   logic              in_ready;
   logic [N_CH-1:0]   ch_mask;
   logic [N_CH-1:0]   ch_ready;
   logic [SEL_W-1:0]  sel;
   logic              en;
   logic [N_CH-1:0]   out_data;
   logic [N_CH-1:0]   out_valid;
   logic              busy;

   modport master (
      output in_valid, in_data, ch_mask, ch_ready,
      input  in_ready, sel, en, out_data, out_valid, busy
   );

   modport slave (
      input  in_valid, in_data, ch_mask, ch_ready,
      output in_ready, sel, en, out_data, out_valid, busy
   );

endinterface
`default_nettype wire

// File: rtl/demux8_rr_sched_rr_pick8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_pick8
// Desc     : Combinational 8-way round-robin picker: first set bit of i_elig
//            starting at i_ptr+1 (mod 8).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module rr_pick8
   import demux8_rr_sched_pkg::*;
(
   input  wire logic [N_CH-1:0]  i_elig,
   input  wire logic [SEL_W-1:0] i_ptr,
   output logic      [SEL_W-1:0] o_pick,
   output logic                  o_any
);

   logic [SEL_W-1:0] w_idx;

   // Walk from the farthest offset inward so the nearest candidate wins last.
   always_comb begin
      o_pick = '0;
      w_idx  = '0;
      for (int i = N_CH; i >= 1; i--) begin
         w_idx = i_ptr + SEL_W'(i);
         if (i_elig[w_idx]) begin
            o_pick = w_idx;
         end
      end
   end

   assign o_any = |i_elig;

endmodule
`default_nettype wire

// File: rtl/demux8_rr_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : demux8_rr_sched
// Desc     : Round-robin scheduler for the 1-to-8 serial demux path.
//            Optional multi-beat grants enabled by macro DEMUX_BURST_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module demux8_rr_sched
   import demux8_rr_sched_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   demux8_rr_sched_if.slave bus
);

   state_t            r_state;
   logic [SEL_W-1:0]  r_ptr;
   logic [SEL_W-1:0]  r_sel;
   logic              r_en;
   logic [N_CH-1:0]   r_out_data;
   logic [N_CH-1:0]   r_out_valid;
`ifdef DEMUX_BURST_EN
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
`endif

   logic [SEL_W-1:0]  w_pick;
   logic              w_any;
   logic              w_sel_ok;
   logic              w_in_ready;
   logic              w_accept;

   rr_pick8 u_pick (
      .i_elig (bus.ch_mask & bus.ch_ready),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_any  (w_any)
   );

   assign w_sel_ok   = bus.ch_ready[r_sel] & bus.ch_mask[r_sel];
   assign w_in_ready = r_en & w_sel_ok;
   assign w_accept   = bus.in_valid & w_in_ready;
`ifdef DEMUX_BURST_EN
   assign w_cnt_nxt  = r_cnt + CNT_W'(1);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= SEL_W'(N_CH - 1);
         r_sel       <= '0;
         r_en        <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= '0;
`ifdef DEMUX_BURST_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_out_valid <= '0;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) r_state <= ST_SEARCH;
            end
            ST_SEARCH: begin
               if (!bus.in_valid) begin
                  r_state <= ST_IDLE;
               end else if (w_any) begin
                  r_sel   <= w_pick;
                  r_en    <= 1'b1;
                  r_state <= ST_XFER;
`ifdef DEMUX_BURST_EN
                  r_cnt   <= '0;
`endif
               end
            end
            ST_XFER: begin
               if (w_accept) begin
                  r_out_data[r_sel]  <= bus.in_data;
                  r_out_valid[r_sel] <= 1'b1;
               end
`ifdef DEMUX_BURST_EN
               if (w_accept) r_cnt <= w_cnt_nxt;
               // Any exit from a burst moves the pointer past the granted channel.
               if (!bus.in_valid || !w_sel_ok ||
                   (w_accept && (w_cnt_nxt == CNT_W'(BURST_LEN)))) begin
                  r_ptr   <= r_sel;
                  r_en    <= 1'b0;
                  r_state <= bus.in_valid ? ST_SEARCH : ST_IDLE;
               end
`else
               if (!bus.in_valid) begin
                  // Source withdrew before the beat: pointer stays, channel keeps its turn.
                  r_en    <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_accept || !w_sel_ok) begin
                  r_ptr   <= r_sel;
                  r_en    <= 1'b0;
                  r_state <= ST_SEARCH;
               end
`endif
            end
            default: begin
               r_en    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.sel       = r_sel;
   assign bus.en        = r_en;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demux8_rr_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_demux8_rr_sched
// Desc     : Self-checking bench for demux8_rr_sched against a grant-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_demux8_rr_sched;

   localparam int TB_BURST = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux8_rr_sched_if bus();

   demux8_rr_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] tb_mask, tb_ready;
   int         m_ptr;
   logic [7:0] m_data;
   bit         m_granted;
   int         m_cur, m_cnt;

   task automatic set_cfg(input logic [7:0] m, input logic [7:0] r);
      tb_mask = m; tb_ready = r;
      bus.ch_mask = m; bus.ch_ready = r;
   endtask

   task automatic model_reset();
      m_ptr = 7; m_data = '0; m_granted = 0; m_cur = 0; m_cnt = 0;
   endtask

   function automatic int model_pick(input logic [7:0] e, input int p);
      for (int k = 1; k <= 8; k++) if (e[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   // One beat: raise valid, wait for in_ready, check grant, pulse and data.
   task automatic do_beat(input logic d, input bit keep_valid, output int ch, output int waits);
      int exp; bit got; logic [7:0] exp_v;
      bus.in_valid = 1'b1; bus.in_data = d;
      got = 0; waits = 0; ch = -1;
      for (int c = 0; c < 40 && !got; c++) begin
         #1;
         if (bus.in_ready === 1'b1) got = 1;
         else begin waits++; @(negedge clk); end
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL beat_timeout: in_ready stayed low, required 1 within 40 cycles");
         bus.in_valid = 1'b0;
         return;
      end
      exp = m_granted ? m_cur : model_pick(tb_mask & tb_ready, m_ptr);
      ch  = int'(bus.sel);
      if (ch != exp) begin
         n_fail++;
         $display("FAIL beat_sel: sel=%0d required %0d", ch, exp);
      end
      if (exp < 0) exp = 0;
      @(posedge clk);
      m_data[exp] = d;
`ifdef DEMUX_BURST_EN
      if (!m_granted) begin m_granted = 1; m_cur = exp; m_cnt = 0; end
      m_cnt++;
      if (m_cnt == TB_BURST) begin m_granted = 0; m_ptr = exp; end
`else
      m_ptr = exp;
`endif
      @(negedge clk);
      exp_v = '0; exp_v[exp] = 1'b1;
      n_chk++;
      if (bus.out_valid !== exp_v) begin
         n_fail++;
         $display("FAIL beat_out_valid: got %b required %b", bus.out_valid, exp_v);
      end
      n_chk++;
      if (bus.out_data !== m_data) begin
         n_fail++;
         $display("FAIL beat_out_data: got %b required %b", bus.out_data, m_data);
      end
      bus.in_valid = keep_valid;
      if (!keep_valid && m_granted) begin m_ptr = m_cur; m_granted = 0; end
   endtask

   task automatic test_reset();
      rst = 1'b0; bus.in_valid = 1'b0; bus.in_data = 1'b0;
      set_cfg(8'h00, 8'h00);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_chk++; if (bus.sel !== 3'd0)       begin n_fail++; $display("FAIL reset_sel: got %0d required 0", bus.sel); end
      n_chk++; if (bus.en !== 1'b0)        begin n_fail++; $display("FAIL reset_en: got %b required 0", bus.en); end
      n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h required 00", bus.out_data); end
      n_chk++; if (bus.out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_out_valid: got %h required 00", bus.out_valid); end
      n_chk++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      n_chk++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
   endtask

   task automatic test_round_robin();
      logic b [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      int ch, w;
      set_cfg(8'hFF, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         do_beat(b[i], i < 7, ch, w);
`ifndef DEMUX_BURST_EN
         n_chk++;
         if (ch != i) begin n_fail++; $display("FAIL rr_order: beat %0d sel=%0d required %0d", i, ch, i); end
         if (i > 0) begin
            n_chk++;
            if (w != 1) begin n_fail++; $display("FAIL rr_search_cycle: beat %0d waited %0d required 1", i, w); end
         end
`endif
      end
`ifndef DEMUX_BURST_EN
      n_chk++;
      if (bus.out_data !== 8'b0100_1101) begin
         n_fail++; $display("FAIL rr_out_data: got %b required 01001101", bus.out_data);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid_xfer();
      int ch, w; bit seen;
      set_cfg(8'hFF, 8'hFF);
      bus.in_valid = 1'b1; bus.in_data = 1'b1; seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.en === 1'b1) seen = 1;
      end
      n_chk++;
      if (!seen) begin n_fail++; $display("FAIL midrst_grant: en stayed 0, required 1 within 10 cycles"); end
      rst = 1'b1;
      #1;
      n_chk++;
      if ({bus.sel, bus.en, bus.in_ready, bus.busy, bus.out_valid, bus.out_data} !== 22'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: sel=%0d en=%b rdy=%b busy=%b ov=%h od=%h required all 0",
                  bus.sel, bus.en, bus.in_ready, bus.busy, bus.out_valid, bus.out_data);
      end
      @(negedge clk);
      bus.in_valid = 1'b0; rst = 1'b0;
      model_reset();
      @(negedge clk);
      do_beat(1'b0, 1'b0, ch, w);
      n_chk++;
      if (ch != 0) begin n_fail++; $display("FAIL midrst_first_grant: sel=%0d required 0", ch); end
      @(negedge clk);
   endtask

   task automatic test_sparse_mask();
      int seq [4] = '{5, 7, 5, 7};
      int ch, w;
      set_cfg(8'b1010_0000, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         do_beat(1'($urandom), i < 3, ch, w);
`ifndef DEMUX_BURST_EN
         n_chk++;
         if (ch != seq[i]) begin n_fail++; $display("FAIL sparse_order: beat %0d sel=%0d required %0d", i, ch, seq[i]); end
`endif
      end
      @(negedge clk);
   endtask

   task automatic test_no_eligible();
      int ch, w;
      set_cfg(8'hFF, 8'h00);
      bus.in_valid = 1'b1; bus.in_data = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         n_chk++;
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_state: busy=%b rdy=%b en=%b required 1/0/0", bus.busy, bus.in_ready, bus.en);
         end
         @(negedge clk);
      end
      set_cfg(8'hFF, 8'h08);
      @(negedge clk);
      n_chk++;
      if (bus.sel !== 3'd3 || bus.en !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: sel=%0d en=%b required 3/1", bus.sel, bus.en);
      end
      do_beat(1'b1, 1'b0, ch, w);
      n_chk++;
      if (w != 0) begin n_fail++; $display("FAIL stall_accept: waited %0d required 0", w); end
      @(negedge clk);
   endtask

   task automatic test_ready_drop();
      int ch, w, exp, s; bit seen; logic [7:0] r;
      set_cfg(8'hFF, 8'hFF);
      bus.in_valid = 1'b1; bus.in_data = 1'b1; seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.en === 1'b1) seen = 1;
      end
      exp = model_pick(8'hFF, m_ptr);
      s   = int'(bus.sel);
      n_chk++;
      if (!seen || s != exp) begin n_fail++; $display("FAIL drop_grant: en=%b sel=%0d required 1/%0d", bus.en, s, exp); end
      r = 8'hFF; r[exp] = 1'b0;
      set_cfg(8'hFF, r);
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_in_ready: got %b required 0", bus.in_ready); end
      @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 8'h00 || bus.en !== 1'b0) begin
         n_fail++; $display("FAIL drop_no_accept: ov=%h en=%b required 00/0", bus.out_valid, bus.en);
      end
      m_ptr = exp; m_granted = 0;
      do_beat(1'b0, 1'b0, ch, w);
      n_chk++;
      if (ch != (exp + 1) % 8) begin n_fail++; $display("FAIL drop_repick: sel=%0d required %0d", ch, (exp + 1) % 8); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int ch, w; logic [7:0] m, r; int k;
      for (int i = 0; i < 30; i++) begin
         m = 8'($urandom); r = 8'($urandom);
         if ((m & r) == 8'h00) begin
            k = int'($urandom_range(0, 7));
            m[k] = 1'b1; r[k] = 1'b1;
         end
         set_cfg(m, r);
         do_beat(1'($urandom), 1'b0, ch, w);
         repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      end
   endtask

`ifdef DEMUX_BURST_EN
   task automatic test_burst();
      int ch, w;
      rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      set_cfg(8'hFF, 8'hFF);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         do_beat(1'($urandom), i < 7, ch, w);
         n_chk++;
         if (ch != (i < 4 ? 0 : 1)) begin n_fail++; $display("FAIL burst_ch: beat %0d sel=%0d required %0d", i, ch, (i < 4 ? 0 : 1)); end
         if (i != 0 && i != 4) begin
            n_chk++;
            if (w != 0) begin n_fail++; $display("FAIL burst_gap: beat %0d waited %0d required 0", i, w); end
         end
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_reset_mid_xfer();
      test_sparse_mask();
      test_no_eligible();
      test_ready_drop();
      test_random();
`ifdef DEMUX_BURST_EN
      test_burst();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
